mem_io_arbiter: RTL and testbench



---
 rtl/mem_io_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/mem_io_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_io_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared state/grant types and IO address decode for the data-side bus arbiter.
// Latency: none, types and a combinational decode helper only.
// Backpressure: none.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_LD  = 1'b1
  } grant_t;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

  // Anything at or above the IO base is IO; the address space does not wrap.
  function automatic logic is_io(input logic [63:0] addr,
                                 input logic [63:0] base = 64'(IO_BASE_DEFAULT));
    return addr >= base;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; side a is the CPU, side b the loader, force_b locks out a.
// Latency: grant is combinational from the requests, last_grant updates on the grant_en edge.
// Backpressure: a losing requester simply sees no grant and keeps requesting.
module rr_arbiter2
  import mem_io_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       force_b,
  input  logic       grant_en,
  output logic [1:0] grant
);

  grant_t last_grant;

  // Pick a winner: force_b ignores a; on a tie the side not granted last time wins.
  always_comb begin
    grant = 2'b00;
    if (force_b) begin
      grant = {req_b, 1'b0};
    end else if (req_a && req_b) begin
      grant = (last_grant == GNT_CPU) ? 2'b10 : 2'b01;
    end else begin
      grant = {req_b, req_a};
    end
  end

  // Remember the most recent winner so the next tie goes the other way.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GNT_LD;
    end else if (grant_en && (grant != 2'b00)) begin
      last_grant <= grant[1] ? GNT_LD : GNT_CPU;
    end
  end

endmodule

// File: rtl/mem_io_arbiter.sv
// Sequences CPU and loader accesses onto the shared data-memory and 24-bit IO ports.
// Latency: write or IO read acks 2 cycles after the IDLE grant, memory read 2+MEM_LAT.
// Backpressure: requester holds req until its one-cycle ack; cpu_stall covers the wait.
module mem_io_arbiter
  import mem_io_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT),
  parameter int                MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_mode,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              io_rd,
  output logic              io_wr,
  output logic [23:0]       io_wdata,
  input  logic [23:0]       io_rdata
);

  // What the FSM needs to remember about the access in flight; address and
  // write data live directly in the dmem_addr / wdata output registers.
  typedef struct packed {
    grant_t gnt;
    logic   we;
    logic   io;
  } txn_t;

  typedef struct packed {
    grant_t            gnt;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t     state;
  txn_t       txn;
  req_t       win;
  logic       win_io;
  logic [1:0] grant;
  logic [1:0] wait_cnt;

  rr_arbiter2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .req_a    (cpu_req),
    .req_b    (ld_req),
    .force_b  (ld_mode),
    .grant_en (state == IDLE),
    .grant    (grant)
  );

  // Route the winning master's request fields into one bundle for latching.
  always_comb begin
    win = '0;
    if (grant[1]) begin
      win.gnt   = GNT_LD;
      win.we    = ld_we;
      win.addr  = ld_addr;
      win.wdata = ld_wdata;
    end else begin
      win.gnt   = GNT_CPU;
      win.we    = cpu_we;
      win.addr  = cpu_addr;
      win.wdata = cpu_wdata;
    end
  end

  assign win_io    = is_io(64'(win.addr), 64'(IO_BASE));
  assign cpu_stall = cpu_req & ~cpu_ack;

  // Transaction FSM; every bus strobe, ack and read-data output is a register here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      txn        <= '0;
      wait_cnt   <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      io_wdata   <= '0;
      dmem_we    <= 1'b0;
      dmem_re    <= 1'b0;
      io_rd      <= 1'b0;
      io_wr      <= 1'b0;
      cpu_ack    <= 1'b0;
      ld_ack     <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          ld_ack  <= 1'b0;
          if (grant != 2'b00) begin
            txn.gnt    <= win.gnt;
            txn.we     <= win.we;
            txn.io     <= win_io;
            dmem_addr  <= win.addr;
            dmem_wdata <= win.wdata;
            io_wdata   <= win.wdata[23:0];
            dmem_we    <= ~win_io &  win.we;
            dmem_re    <= ~win_io & ~win.we;
            io_wr      <=  win_io &  win.we;
            io_rd      <=  win_io & ~win.we;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          dmem_we    <= 1'b0;
          dmem_re    <= 1'b0;
          io_wr      <= 1'b0;
          io_rd      <= 1'b0;
          dmem_wdata <= '0;
          io_wdata   <= '0;
          if (!txn.we && !txn.io) begin
            wait_cnt <= 2'(MEM_LAT);
            state    <= WAIT;
          end else begin
            // IO read data is only valid while io_rd is high, so capture it now.
            if (!txn.we) begin
              if (txn.gnt == GNT_LD) ld_rdata  <= DATA_W'(io_rdata);
              else                   cpu_rdata <= DATA_W'(io_rdata);
            end
            cpu_ack <= (txn.gnt == GNT_CPU);
            ld_ack  <= (txn.gnt == GNT_LD);
            state   <= DONE;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd1) begin
            if (txn.gnt == GNT_LD) ld_rdata  <= dmem_rdata;
            else                   cpu_rdata <= dmem_rdata;
            cpu_ack  <= (txn.gnt == GNT_CPU);
            ld_ack   <= (txn.gnt == GNT_LD);
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        DONE: begin
          cpu_ack <= 1'b0;
          ld_ack  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Bench for mem_io_arbiter: vector table of single-master accesses plus hand sequences.
// Latency: MEM_LAT fixed at 2 for the whole run.
// Backpressure: requesters hold req until ack; a scoreboard checks ack order and read data.
module tb_mem_io_arbiter;

  localparam int MEM_LAT = 2;

  logic        clock = 1'b0;
  logic        reset, ld_mode;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ld_req, ld_we, ld_ack;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we, dmem_re, io_rd, io_wr;
  logic [23:0] io_wdata, io_rdata;

  logic [31:0] mem_val = 32'h0;
  logic [23:0] io_val  = 24'h0;
  logic [31:0] pipe0, pipe1;
  logic [3:0]  strb;
  logic        stall_low = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  typedef struct {
    logic        is_ld;
    logic        we;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        is_ld;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_val;
    logic [23:0] io_val;
    logic [3:0]  strobe;   // {io_wr, io_rd, dmem_re, dmem_we} in the ACCESS cycle
    int          lat;      // ack cycle, counted from the request cycle 0
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[9];

  mem_io_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset), .ld_mode(ld_mode),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata), .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata),
    .io_rdata(io_rdata)
  );

  always #5 clock = ~clock;

  // Memory model: data appears MEM_LAT cycles after the read strobe, garbage otherwise.
  always @(posedge clock) begin
    pipe0 <= dmem_re ? mem_val : 32'hBAD0_BAD0;
    pipe1 <= pipe0;
  end
  assign dmem_rdata = (MEM_LAT == 1) ? pipe0 : pipe1;
  assign io_rdata   = io_rd ? io_val : 24'h0;
  assign strb       = {io_wr, io_rd, dmem_re, dmem_we};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"},    32'(strb), 0);
    check({tag, "_acks"},       {30'b0, cpu_ack, ld_ack}, 0);
    check({tag, "_dmem_addr"},  dmem_addr, 0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 0);
    check({tag, "_io_wdata"},   32'(io_wdata), 0);
    check({tag, "_cpu_rdata"},  cpu_rdata, 0);
    check({tag, "_ld_rdata"},   ld_rdata, 0);
    check({tag, "_cpu_stall"},  32'(cpu_stall), 0);
  endtask

  // Scoreboard: every ack must match the oldest expected transaction.
  always @(negedge clock) begin
    sb_t e;
    if (cpu_ack || ld_ack) begin
      check("sb_expected_ack", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ack_master", {30'b0, ld_ack, cpu_ack}, e.is_ld ? 2 : 1);
        if (!e.we) check("rdata", e.is_ld ? ld_rdata : cpu_rdata, e.rdata);
      end
    end
  end

  task automatic wait_ack(input logic who, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (!cpu_stall) stall_low = 1'b1;
    end while (!(who ? ld_ack : cpu_ack) && cyc < budget);
    check(who ? "ld_ack_in_budget" : "cpu_ack_in_budget", 32'(who ? ld_ack : cpu_ack), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; ld_mode = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int         cyc;
    logic [3:0] late;
    mem_val = v.mem_val;
    io_val  = v.io_val;
    sb.push_back('{v.is_ld, v.we, v.rdata});
    @(posedge clock); #1;
    if (v.is_ld) begin
      ld_req = 1'b1; ld_we = v.we; ld_addr = v.addr; ld_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(negedge clock);
    check("c0_strobes", 32'(strb), 0);
    if (!v.is_ld) check("c0_cpu_stall", 32'(cpu_stall), 1);
    @(negedge clock);
    check("c1_strobes", 32'(strb), 32'(v.strobe));
    check("c1_dmem_addr", dmem_addr, v.addr);
    if (v.we) begin
      if (v.strobe[3]) check("c1_io_wdata", 32'(io_wdata), 32'(v.wdata[23:0]));
      else             check("c1_dmem_wdata", dmem_wdata, v.wdata);
    end
    if (!v.is_ld) check("c1_cpu_stall", 32'(cpu_stall), 1);
    cyc  = 1;
    late = 4'b0;
    while (!(v.is_ld ? ld_ack : cpu_ack) && cyc < v.lat + 8) begin
      @(negedge clock);
      cyc++;
      late |= strb;
    end
    check("ack_latency", 32'(cyc), 32'(v.lat));
    check("strobe_after_access", 32'(late), 0);
    if (v.is_ld) ld_req = 1'b0;
    else         cpu_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    //            is_ld we  addr           wdata          mem_val        io_val      strobe  lat rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,         24'h0,      4'b0001, 2, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 24'h0,      4'b0010, 4, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FC60, 32'h0,         32'h0,         24'hABCDEF, 4'b0100, 2, 32'h00AB_CDEF};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FBFC, 32'hCAFE_F00D, 32'h0,         24'h0,      4'b0001, 2, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FC00, 32'hA511_2233, 32'h0,         24'h0,      4'b1000, 2, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         24'h123456, 4'b0100, 2, 32'h0012_3456};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0020, 32'h55AA_55AA, 32'h0,         24'h0,      4'b0001, 2, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0024, 32'h0,         32'h0F0F_0F0F, 24'h0,      4'b0010, 4, 32'h0F0F_0F0F};
    vecs[8] = '{1'b0, 1'b0, 32'hFFFF_FBFC, 32'h0,         32'h1111_2222, 24'h0,      4'b0010, 4, 32'h1111_2222};

    do_reset();

    // Both masters keep re-requesting: CPU wins first out of reset, then strict alternation.
    repeat (3) begin
      sb.push_back('{1'b0, 1'b1, 32'h0});
      sb.push_back('{1'b1, 1'b1, 32'h0});
    end
    fork
      begin
        int c;
        for (int i = 0; i < 3; i++) begin
          @(posedge clock); #1;
          cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100 + 32'(i) * 4; cpu_wdata = 32'(i);
          wait_ack(1'b0, 40, c);
          cpu_req = 1'b0;
        end
      end
      begin
        int c;
        for (int i = 0; i < 3; i++) begin
          @(posedge clock); #1;
          ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h200 + 32'(i) * 4; ld_wdata = 32'(i);
          wait_ack(1'b1, 40, c);
          ld_req = 1'b0;
        end
      end
    join

    foreach (vecs[i]) run_vec(vecs[i]);

    // Download mode: loader served three times while the CPU stays stalled.
    ld_mode = 1'b1;
    repeat (3) sb.push_back('{1'b1, 1'b1, 32'h0});
    sb.push_back('{1'b0, 1'b1, 32'h0});
    stall_low = 1'b0;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h7777_0000;
    for (int i = 0; i < 3; i++) begin
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h50 + 32'(i) * 4; ld_wdata = 32'(i);
      wait_ack(1'b1, 20, cyc);
      ld_req = 1'b0;
      if (i < 2) begin
        @(posedge clock); #1;
      end
    end
    check("cpu_stall_held_in_ld_mode", 32'(stall_low), 0);
    ld_mode = 1'b0;
    wait_ack(1'b0, 20, cyc);
    check("cpu_served_after_ld_mode", 32'(cyc), 3);
    cpu_req = 1'b0;

    // Reset during WAIT of a memory read: no ack, everything cleared, then a clean read.
    mem_val = 32'h3333_4444;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    @(negedge clock);
    @(negedge clock);
    check("rstwait_c1_dmem_re", 32'(dmem_re), 1);
    @(posedge clock); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("rstwait");
    repeat (8) @(negedge clock);
    run_vec(vecs[1]);

    repeat (4) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
